// File: rtl/lsr_window_loader_if.sv
// Sample stream, window bus and LSR3 handshake between the window loader and its neighbours.
// The master side is the environment (sample source and LSR3 core); the slave side is the loader.
interface lsr_window_loader_if #(
  parameter int unsigned DATA_SIZE = 7,
  parameter int unsigned WIDTH     = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data;
  logic                       flush;
  logic [15:0]                shift_cfg;
  logic [DATA_SIZE*WIDTH-1:0] win_data;
  logic [15:0]                shift;
  logic                       start;
  logic                       lsr_done;
  logic [15:0]                win_count;

  modport master (
    output in_valid, in_data, flush, shift_cfg, lsr_done,
    input  in_ready, win_data, shift, start, win_count
  );

  modport slave (
    input  in_valid, in_data, flush, shift_cfg, lsr_done,
    output in_ready, win_data, shift, start, win_count
  );
endinterface

// File: rtl/lsr_window_loader.sv
// Sliding-window feeder for the LSR3 core: collects DATA_SIZE samples, raises start until done,
// then slides the window by HOP fresh samples before firing again.
module lsr_window_loader #(
  parameter int unsigned DATA_SIZE = 7,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned HOP       = 1
) (
  input logic                clk,
  input logic                rst_n,
  lsr_window_loader_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(DATA_SIZE + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DATA_SIZE);
  localparam logic [CntW-1:0] HopFull = CntW'(HOP);

  typedef enum logic [1:0] {StFill, StBusy, StSlide} state_e;

  state_e                     r_state;
  logic [WIDTH-1:0]           r_win [DATA_SIZE];
  logic [CntW-1:0]            r_cnt;
  logic [CntW-1:0]            r_hop;
  logic                       r_ready;
  logic                       r_start;
  logic [15:0]                r_shift;
  logic [15:0]                r_win_count;

  logic                       w_accept;
  logic [CntW-1:0]            w_cnt_inc;
  logic [CntW-1:0]            w_hop_inc;
  logic [DATA_SIZE*WIDTH-1:0] w_win_flat;

  assign w_accept  = bus.in_valid && r_ready;
  assign w_cnt_inc = (r_cnt == CntFull) ? r_cnt : r_cnt + 1'b1;
  assign w_hop_inc = r_hop + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StFill;
      r_cnt       <= '0;
      r_hop       <= '0;
      r_ready     <= 1'b0;
      r_start     <= 1'b0;
      r_shift     <= '0;
      r_win_count <= '0;
      for (int i = 0; i < DATA_SIZE; i++) r_win[i] <= '0;
    end else if (bus.flush) begin
      // Flush beats a same-cycle accept or lsr_done; the window count survives.
      r_state <= StFill;
      r_cnt   <= '0;
      r_hop   <= '0;
      r_ready <= 1'b1;
      r_start <= 1'b0;
      for (int i = 0; i < DATA_SIZE; i++) r_win[i] <= '0;
    end else begin
      if (w_accept) begin
        for (int i = 0; i < DATA_SIZE - 1; i++) r_win[i] <= r_win[i+1];
        r_win[DATA_SIZE-1] <= bus.in_data;
      end
      case (r_state)
        StFill: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == CntFull) begin
              r_state <= StBusy;
              r_start <= 1'b1;
              r_shift <= bus.shift_cfg;
              r_ready <= 1'b0;
            end
          end
        end
        StBusy: begin
          if (bus.lsr_done) begin
            r_state     <= StSlide;
            r_start     <= 1'b0;
            r_hop       <= '0;
            r_ready     <= 1'b1;
            r_win_count <= r_win_count + 16'd1;
          end
        end
        StSlide: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_hop <= w_hop_inc;
            if (w_hop_inc == HopFull) begin
              r_state <= StBusy;
              r_start <= 1'b1;
              r_shift <= bus.shift_cfg;
              r_ready <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= StFill;
          r_ready <= 1'b1;
          r_start <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_win_flat = '0;
    for (int i = 0; i < DATA_SIZE; i++) w_win_flat[i*WIDTH +: WIDTH] = r_win[i];
  end

  assign bus.win_data  = w_win_flat;
  assign bus.in_ready  = r_ready;
  assign bus.start     = r_start;
  assign bus.shift     = r_shift;
  assign bus.win_count = r_win_count;

endmodule

// File: tb/tb_lsr_window_loader.sv
// Bench for lsr_window_loader: two instances (HOP=1 and HOP=3) share one stimulus stream and are
// compared against a queue-based window model and a scoreboard of expected window firings.
module tb_lsr_window_loader;
  localparam int unsigned DS = 7;
  localparam int unsigned W  = 16;

  typedef struct packed {
    logic [DS*W-1:0] win;
    logic [15:0]     shift;
  } fire_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         d_valid = 1'b0;
  logic [W-1:0] d_data = '0;
  logic         d_flush = 1'b0;
  logic [15:0]  d_cfg = '0;
  logic         d_done = 1'b0;

  lsr_window_loader_if #(.DATA_SIZE(DS), .WIDTH(W)) bus_a ();
  lsr_window_loader_if #(.DATA_SIZE(DS), .WIDTH(W)) bus_b ();

  assign bus_a.in_valid  = d_valid;
  assign bus_a.in_data   = d_data;
  assign bus_a.flush     = d_flush;
  assign bus_a.shift_cfg = d_cfg;
  assign bus_a.lsr_done  = d_done;
  assign bus_b.in_valid  = d_valid;
  assign bus_b.in_data   = d_data;
  assign bus_b.flush     = d_flush;
  assign bus_b.shift_cfg = d_cfg;
  assign bus_b.lsr_done  = d_done;

  lsr_window_loader #(.DATA_SIZE(DS), .WIDTH(W), .HOP(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  lsr_window_loader #(.DATA_SIZE(DS), .WIDTH(W), .HOP(3)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  logic [1:0]      mon_ready, mon_start;
  logic [DS*W-1:0] mon_win   [2];
  logic [15:0]     mon_shift [2];
  logic [15:0]     mon_count [2];
  assign mon_ready    = {bus_b.in_ready, bus_a.in_ready};
  assign mon_start    = {bus_b.start, bus_a.start};
  assign mon_win[0]   = bus_a.win_data;
  assign mon_win[1]   = bus_b.win_data;
  assign mon_shift[0] = bus_a.shift;
  assign mon_shift[1] = bus_b.shift;
  assign mon_count[0] = bus_a.win_count;
  assign mon_count[1] = bus_b.win_count;

  // Reference model: window is the last DS accepted samples (zeros after reset/flush).
  logic [W-1:0] m_win [2][$];
  int           m_mode [2];  // 0 collecting first window, 1 waiting on LSR3, 2 collecting hop
  int           m_need [2];
  bit           m_ready [2];
  bit           m_start [2];
  logic [15:0]  m_shift [2];
  logic [15:0]  m_count [2];
  fire_t        sb_q [2][$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] t4_vals [7];

  function automatic int hop_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [DS*W-1:0] pack_win(int k);
    logic [DS*W-1:0] v;
    v = '0;
    for (int i = 0; i < DS; i++) v[i*W +: W] = m_win[k][i];
    return v;
  endfunction

  task automatic check(string name, int k, logic [DS*W-1:0] act, logic [DS*W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  task automatic clear_win(int k);
    m_win[k].delete();
    for (int i = 0; i < DS; i++) m_win[k].push_back('0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      clear_win(k);
      m_mode[k]  = 0;
      m_need[k]  = DS;
      m_ready[k] = 1'b0;
      m_start[k] = 1'b0;
      m_shift[k] = '0;
      m_count[k] = '0;
      sb_q[k].delete();
    end
  endtask

  // Advance the model across the coming clock edge using the inputs now on the bus.
  task automatic model_step();
    fire_t f;
    bit    acc;
    for (int k = 0; k < 2; k++) begin
      acc = d_valid && m_ready[k];
      if (d_flush) begin
        clear_win(k);
        m_mode[k]  = 0;
        m_need[k]  = DS;
        m_start[k] = 1'b0;
        m_ready[k] = 1'b1;
      end else if (m_mode[k] == 1) begin
        if (d_done) begin
          m_start[k] = 1'b0;
          m_count[k] = m_count[k] + 16'd1;
          m_mode[k]  = 2;
          m_need[k]  = hop_of(k);
          m_ready[k] = 1'b1;
        end
      end else begin
        m_ready[k] = 1'b1;
        if (acc) begin
          m_win[k].push_back(d_data);
          void'(m_win[k].pop_front());
          m_need[k]--;
          if (m_need[k] == 0) begin
            m_mode[k]  = 1;
            m_start[k] = 1'b1;
            m_shift[k] = d_cfg;
            m_ready[k] = 1'b0;
            f.win      = pack_win(k);
            f.shift    = d_cfg;
            sb_q[k].push_back(f);
          end
        end
      end
    end
  endtask

  task automatic cyc(bit v, logic [W-1:0] d, bit fl, logic [15:0] cfg, bit dn);
    @(negedge clk);
    #1;
    d_valid = v;
    d_data  = d;
    d_flush = fl;
    d_cfg   = cfg;
    d_done  = dn;
    model_step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, d_cfg, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    d_valid = 1'b0;
    d_flush = 1'b0;
    d_done  = 1'b0;
    rst_n   = 1'b1;
    model_step();
  endtask

  // Monitor: per-cycle state checks plus scoreboard pop on every rising start.
  initial begin
    fire_t    f;
    bit [1:0] prev_start;
    prev_start = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check("in_ready", k, mon_ready[k], m_ready[k]);
        check("start", k, mon_start[k], m_start[k]);
        check("win_count", k, mon_count[k], m_count[k]);
        check("win_data", k, mon_win[k], pack_win(k));
        if (m_start[k]) check("shift", k, mon_shift[k], m_shift[k]);
        if (mon_start[k] && !prev_start[k]) begin
          if (sb_q[k].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL fire_unexpected dut%0d @%0t: got start=1, expected no window", k, $time);
          end else begin
            f = sb_q[k].pop_front();
            check("fire_win", k, mon_win[k], f.win);
            check("fire_shift", k, mon_shift[k], f.shift);
          end
        end
        prev_start[k] = mon_start[k];
      end
    end
  end

  initial begin
    t4_vals = '{16'h8000, 16'hFFFF, 16'h0000, 16'h0001, 16'h7FFF, 16'hFFFB, 16'h0005};
    model_reset();
    repeat (2) @(negedge clk);
    release_reset();
    idle(1);

    // T1/T2: fill 1..7, hold BUSY with in_valid high, then release with lsr_done
    for (int i = 1; i <= 7; i++) cyc(1'b1, W'(i), 1'b0, 16'd5, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 16'hAAAA, 1'b0, 16'd5, 1'b0);
    cyc(1'b0, '0, 1'b0, 16'd5, 1'b1);
    idle(1);

    // T3: slide; HOP=1 fires on 8, HOP=3 on 10
    for (int i = 8; i <= 10; i++) cyc(1'b1, W'(i), 1'b0, 16'd6, 1'b0);
    idle(2);
    cyc(1'b0, '0, 1'b0, 16'd6, 1'b1);

    // T4: signed extremes with shift_cfg=3, then shift_cfg wanders while BUSY
    cyc(1'b0, '0, 1'b1, 16'd0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, t4_vals[i], 1'b0, 16'd3, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h1234, 1'b0, 16'($urandom), 1'b0);
    cyc(1'b0, '0, 1'b0, 16'd9, 1'b1);

    // T5: flush after 4, 7 more to fire, then flush colliding with done on first BUSY cycle
    cyc(1'b0, '0, 1'b1, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, W'(100 + i), 1'b0, 16'd1, 1'b0);
    cyc(1'b1, 16'd999, 1'b1, 16'd1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, W'(200 + i), 1'b0, 16'd2, 1'b0);
    cyc(1'b1, 16'd77, 1'b1, 16'd2, 1'b1);
    idle(2);
    // done honoured on the first BUSY cycle
    for (int i = 0; i < 7; i++) cyc(1'b1, W'(300 + i), 1'b0, 16'd4, 1'b0);
    cyc(1'b0, '0, 1'b0, 16'd4, 1'b1);
    idle(1);

    // T6: asynchronous reset mid-BUSY, checked before any clock edge, then refill
    cyc(1'b0, '0, 1'b1, 16'd0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, W'(400 + i), 1'b0, 16'd8, 1'b0);
    idle(2);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_start", 0, bus_a.start, 1'b0);
    check("async_win", 0, bus_a.win_data, '0);
    check("async_ready", 0, bus_a.in_ready, 1'b0);
    check("async_count", 0, bus_a.win_count, '0);
    check("async_start", 1, bus_b.start, 1'b0);
    check("async_win", 1, bus_b.win_data, '0);
    model_reset();
    release_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, W'(500 + i), 1'b0, 16'd11, 1'b0);
    idle(2);
    cyc(1'b0, '0, 1'b0, 16'd11, 1'b1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 63) == 0,
          16'($urandom), $urandom_range(0, 3) == 0);
    end
    idle(3);

    for (int k = 0; k < 2; k++) check("sb_drain", k, sb_q[k].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
